// File: rtl/bus_rx_buffer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bus_rx_buffer_pkg
// Description : Shared constants, packet type and pointer-width helper for the
//               bus receive buffer.
// Revision    : 1.0 - initial release
// ============================================================================
package bus_rx_buffer_pkg;

    localparam int c_data_packet_size = 32;
    localparam int c_depth            = 4;

    typedef logic [c_data_packet_size-1:0] packet_t;

    function automatic int ptr_w(input int depth);
        return $clog2(depth);
    endfunction

endpackage
`default_nettype wire

// File: rtl/bus_rx_buffer_if.sv
`default_nettype none
// ============================================================================
// Module      : bus_rx_buffer_if
// Description : Ready/valid link carrying packets from source to sink.
// Revision    : 1.0 - initial release
// ============================================================================
interface bus_rx_buffer_if
    import bus_rx_buffer_pkg::*;
#(
    parameter int DATA_PACKET_SIZE = c_data_packet_size
);

    logic                        valid;
    logic [DATA_PACKET_SIZE-1:0] data;
    logic                        ready;

    modport source (output valid, output data, input  ready);
    modport sink   (input  valid, input  data, output ready);

    // Aliases for blocks written in master/slave terms
    modport master (output valid, output data, input  ready);
    modport slave  (input  valid, input  data, output ready);

endinterface
`default_nettype wire

// File: rtl/bus_fifo_mem.sv
`default_nettype none
// ============================================================================
// Module      : bus_fifo_mem
// Description : DEPTH x DATA_PACKET_SIZE register array, one synchronous write
//               port and one combinational read port, storage not reset.
// Revision    : 1.0 - initial release
// ============================================================================
module bus_fifo_mem
    import bus_rx_buffer_pkg::*;
#(
    parameter int DATA_PACKET_SIZE = c_data_packet_size,
    parameter int DEPTH            = c_depth
) (
    input  wire                          clk,
    input  wire                          i_we,
    input  wire [ptr_w(DEPTH)-1:0]       i_waddr,
    input  wire [DATA_PACKET_SIZE-1:0]   i_wdata,
    input  wire [ptr_w(DEPTH)-1:0]       i_raddr,
    output logic [DATA_PACKET_SIZE-1:0]  o_rdata
);

    logic [DATA_PACKET_SIZE-1:0] r_mem [DEPTH];

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            always_ff @(posedge clk) begin
                if (i_we && (i_waddr == ptr_w(DEPTH)'(gi))) begin
                    r_mem[gi] <= i_wdata;
                end
            end
        end
    endgenerate

    assign o_rdata = r_mem[i_raddr];

endmodule
`default_nettype wire

// File: rtl/bus_rx_buffer.sv
`default_nettype none
// ============================================================================
// Module      : bus_rx_buffer
// Description : Sink-end receive FIFO with registered ready and a show-ahead
//               registered head, giving a register cut on every link path.
// Revision    : 1.0 - initial release
// ============================================================================
module bus_rx_buffer
    import bus_rx_buffer_pkg::*;
#(
    parameter int DATA_PACKET_SIZE = c_data_packet_size,
    parameter int DEPTH            = c_depth
) (
    input  wire                      clk,
    input  wire                      rst,
    bus_rx_buffer_if.sink            in_bus,
    bus_rx_buffer_if.source          out_bus,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int c_ptr_w = ptr_w(DEPTH);
    localparam int c_lvl_w = c_ptr_w + 1;
    localparam logic [c_lvl_w-1:0] c_full = c_lvl_w'(DEPTH);

    logic [c_ptr_w-1:0]          r_wr_ptr;
    logic [c_ptr_w-1:0]          r_rd_ptr;
    logic [c_lvl_w-1:0]          r_level;
    logic                        r_in_ready;
    logic                        r_out_valid;
    logic [DATA_PACKET_SIZE-1:0] r_out_data;

    logic                        w_push;
    logic                        w_pop;
    logic [c_ptr_w-1:0]          w_wr_ptr_next;
    logic [c_ptr_w-1:0]          w_rd_ptr_next;
    logic [c_lvl_w-1:0]          w_level_after_pop;
    logic [c_lvl_w-1:0]          w_level_next;
    logic                        w_head_from_input;
    logic [DATA_PACKET_SIZE-1:0] w_mem_rdata;
    logic [DATA_PACKET_SIZE-1:0] w_head_next;

    assign w_push = in_bus.valid && r_in_ready;
    assign w_pop  = r_out_valid && out_bus.ready;

    always_comb begin
        w_wr_ptr_next     = r_wr_ptr + c_ptr_w'(w_push);
        w_rd_ptr_next     = r_rd_ptr + c_ptr_w'(w_pop);
        w_level_after_pop = r_level - c_lvl_w'(w_pop);
        w_level_next      = w_level_after_pop + c_lvl_w'(w_push);
        // The new head is the word being written right now whenever nothing
        // older survives this edge; storage has not captured it yet.
        w_head_from_input = w_push && (w_level_after_pop == '0);
        w_head_next       = w_head_from_input ? in_bus.data : w_mem_rdata;
    end

    bus_fifo_mem #(
        .DATA_PACKET_SIZE (DATA_PACKET_SIZE),
        .DEPTH            (DEPTH)
    ) u_mem (
        .clk     (clk),
        .i_we    (w_push),
        .i_waddr (r_wr_ptr),
        .i_wdata (in_bus.data),
        .i_raddr (w_rd_ptr_next),
        .o_rdata (w_mem_rdata)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_level     <= '0;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
        end else begin
            r_wr_ptr    <= w_wr_ptr_next;
            r_rd_ptr    <= w_rd_ptr_next;
            r_level     <= w_level_next;
            r_in_ready  <= (w_level_next != c_full);
            r_out_valid <= (w_level_next != '0);
            // Hold the last head when draining to empty
            if (w_level_next != '0) begin
                r_out_data <= w_head_next;
            end
        end
    end

    assign in_bus.ready  = r_in_ready;
    assign out_bus.valid = r_out_valid;
    assign out_bus.data  = r_out_data;
    assign level         = r_level;

endmodule
`default_nettype wire

// File: tb/tb_bus_rx_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_bus_rx_buffer
// Description : Scoreboard bench for bus_rx_buffer: directed scenarios plus
//               randomized valid/ready traffic with a mid-stream reset.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bus_rx_buffer;
    import bus_rx_buffer_pkg::*;

    localparam int W = 32;
    localparam int D = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [$clog2(D):0] level;

    bus_rx_buffer_if #(.DATA_PACKET_SIZE(W)) in_bus ();
    bus_rx_buffer_if #(.DATA_PACKET_SIZE(W)) out_bus ();

    bus_rx_buffer #(
        .DATA_PACKET_SIZE (W),
        .DEPTH            (D)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .in_bus  (in_bus),
        .out_bus (out_bus),
        .level   (level)
    );

    always #5 clk = ~clk;

    int           n_checks = 0;
    int           n_errors = 0;
    int           n_pops   = 0;
    int           cyc_since_rst = 0;
    logic [W-1:0] sb [$];
    logic         prev_stall = 1'b0;
    logic [W-1:0] prev_data  = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: model occupancy is the scoreboard length; handshakes are
    // judged at the falling edge, ahead of the rising edge that commits them.
    always @(negedge clk) begin : mon
        logic [W-1:0] exp_d;
        if (rst) begin
            sb.delete();
            cyc_since_rst = 0;
            prev_stall    = 1'b0;
        end else begin
            chk("level", 64'(level), 64'(sb.size()));
            chk("out_valid", 64'(out_bus.valid), 64'(sb.size() != 0));
            chk("in_ready", 64'(in_bus.ready), 64'((cyc_since_rst != 0) && (sb.size() != D)));
            if (prev_stall) begin
                chk("stall_valid", 64'(out_bus.valid), 64'd1);
                chk("stall_data", 64'(out_bus.data), 64'(prev_data));
            end
            if (out_bus.valid && out_bus.ready) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL pop_underflow: got data 0x%0h expected no valid", out_bus.data);
                end else begin
                    exp_d = sb.pop_front();
                    chk("head_data", 64'(out_bus.data), 64'(exp_d));
                    n_pops++;
                end
            end
            if (in_bus.valid && in_bus.ready) sb.push_back(in_bus.data);
            prev_stall = out_bus.valid && !out_bus.ready;
            prev_data  = out_bus.data;
            cyc_since_rst++;
        end
    end

    initial begin : stim
        int p0;
        in_bus.valid  = 1'b0;
        in_bus.data   = '0;
        out_bus.ready = 1'b0;

        // Reset release
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rel_ready0", 64'(in_bus.ready), 64'd0);
        chk("rel_valid0", 64'(out_bus.valid), 64'd0);
        chk("rel_level0", 64'(level), 64'd0);
        @(negedge clk);
        chk("rel_ready1", 64'(in_bus.ready), 64'd1);
        tick();

        // Single packet, one-cycle latency
        in_bus.valid  = 1'b1;
        in_bus.data   = 32'hA5A5_0001;
        out_bus.ready = 1'b1;
        tick();
        in_bus.valid = 1'b0;
        in_bus.data  = 'x;
        @(negedge clk);
        chk("single_valid", 64'(out_bus.valid), 64'd1);
        chk("single_data", 64'(out_bus.data), 64'hA5A5_0001);
        chk("single_level1", 64'(level), 64'd1);
        tick();
        @(negedge clk);
        chk("single_level0", 64'(level), 64'd0);
        tick();

        // Fill to full with consumer stalled
        out_bus.ready = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            in_bus.valid = 1'b1;
            in_bus.data  = W'(k);
            tick();
        end
        in_bus.data = 32'h5;
        @(negedge clk);
        chk("fill_level", 64'(level), 64'd4);
        chk("fill_ready", 64'(in_bus.ready), 64'd0);
        chk("fill_head", 64'(out_bus.data), 64'h1);
        tick();
        tick();
        @(negedge clk);
        chk("fill_no_5th", 64'(level), 64'd4);
        chk("fill_head_hold", 64'(out_bus.data), 64'h1);
        tick();
        in_bus.valid = 1'b0;

        // One pop from full, then refill
        out_bus.ready = 1'b1;
        tick();
        out_bus.ready = 1'b0;
        @(negedge clk);
        chk("pop_level", 64'(level), 64'd3);
        chk("pop_ready", 64'(in_bus.ready), 64'd1);
        tick();
        in_bus.valid = 1'b1;
        in_bus.data  = 32'h5;
        tick();
        in_bus.valid = 1'b0;
        @(negedge clk);
        chk("refill_head", 64'(out_bus.data), 64'h2);
        tick();
        out_bus.ready = 1'b1;
        repeat (5) tick();
        @(negedge clk);
        chk("drain_level", 64'(level), 64'd0);
        tick();

        // Streaming: one transfer per cycle, level steady at one
        p0 = n_pops;
        for (int i = 0; i < 100; i++) begin
            in_bus.valid = 1'b1;
            in_bus.data  = 32'h100 + W'(i);
            @(negedge clk);
            chk("stream_level", 64'(level), (i == 0) ? 64'd0 : 64'd1);
            chk("stream_ready", 64'(in_bus.ready), 64'd1);
            tick();
        end
        in_bus.valid = 1'b0;
        repeat (3) tick();
        @(negedge clk);
        chk("stream_count", 64'(n_pops - p0), 64'd100);
        tick();

        // Random traffic with a reset in the middle
        for (int i = 0; i < 1000; i++) begin
            if (i == 500) begin
                in_bus.valid = 1'b0;
                @(posedge clk);
                #2 rst = 1'b1;
                #1;
                chk("mid_rst_level", 64'(level), 64'd0);
                chk("mid_rst_valid", 64'(out_bus.valid), 64'd0);
                chk("mid_rst_ready", 64'(in_bus.ready), 64'd0);
                @(posedge clk);
                #1 rst = 1'b0;
            end else begin
                in_bus.valid  = ($urandom_range(0, 2) != 0);
                in_bus.data   = in_bus.valid ? W'($urandom) : 'x;
                out_bus.ready = ($urandom_range(0, 2) != 0);
                tick();
            end
        end
        in_bus.valid  = 1'b0;
        out_bus.ready = 1'b1;
        repeat (D + 2) tick();
        @(negedge clk);
        chk("final_level", 64'(level), 64'd0);
        chk("final_sb_empty", 64'(sb.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
